// File: rtl/mmio_key_device_pkg.sv
// Shared constants for the key device: default geometry, KCTRL bit positions and
// register addresses, so controller and test code agree on a single definition.
package mmio_key_device_pkg;

  localparam int DBITS_DEF         = 32;
  localparam int ADDR_W_DEF        = 30;
  localparam int NKEYS_DEF         = 4;
  localparam int DEBOUNCE_DEF      = 50000;

  localparam logic [31:0] KDATA_BYTE_ADDR = 32'hFFFF_F080;
  localparam logic [31:0] KCTRL_BYTE_ADDR = 32'hFFFF_F084;

  localparam int KCTRL_RDY = 0;
  localparam int KCTRL_OVR = 2;
  localparam int KCTRL_IE  = 4;

  function automatic logic [29:0] byte_to_word(input logic [31:0] b);
    return 30'(b >> 2);
  endfunction

  function automatic logic [KCTRL_IE:0] pack_kctrl(input logic rdy, input logic ovr,
                                                   input logic ie);
    logic [KCTRL_IE:0] v;
    v            = '0;
    v[KCTRL_RDY] = rdy;
    v[KCTRL_OVR] = ovr;
    v[KCTRL_IE]  = ie;
    return v;
  endfunction

endpackage

// File: rtl/mmio_key_device_if.sv
// Processor data-bus slice seen by the key device: word address, strobes, data.
// Reads are combinational; the target never stalls the initiator.
interface mmio_key_device_if #(
  parameter int DBITS          = 32,
  parameter int ADDR_BIT_WIDTH = 30
);

  logic [ADDR_BIT_WIDTH-1:0] addr;
  logic                      en_write;
  logic                      en_read;
  logic [DBITS-1:0]          data_in;
  logic [DBITS-1:0]          data_out;
  logic                      sel;

  modport master (
    output addr, en_write, en_read, data_in,
    input  data_out, sel
  );

  modport slave (
    input  addr, en_write, en_read, data_in,
    output data_out, sel
  );

endinterface

// File: rtl/mmio_key_device_key_debouncer.sv
// One key: 2-flop synchroniser then a stability counter; o_chg pulses on the edge
// where o_stable takes the new level (2+DEBOUNCE_CYCLES edges after a clean change).
module mmio_key_device_key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key_n,
  output logic o_stable,
  output logic o_chg
);

  localparam int             CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_done;

  assign w_diff = r_sync2 ^ r_stable;
  assign w_done = w_diff && (r_cnt == LAST);

  // Any cycle where the synchronised level matches the accepted one restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;
  assign o_chg    = w_done;

endmodule

// File: rtl/mmio_key_device.sv
// Memory-mapped push-button target: debounced KDATA plus KCTRL (rdy/ovr/ie) and irq.
// Reads are combinational in the address cycle; stores take effect on the clock edge.
module mmio_key_device
  import mmio_key_device_pkg::*;
#(
  parameter int                        DBITS           = DBITS_DEF,
  parameter int                        ADDR_BIT_WIDTH  = ADDR_W_DEF,
  parameter int                        NKEYS           = NKEYS_DEF,
  parameter logic [ADDR_BIT_WIDTH-1:0] KDATA_ADDR      = ADDR_BIT_WIDTH'(byte_to_word(KDATA_BYTE_ADDR)),
  parameter logic [ADDR_BIT_WIDTH-1:0] KCTRL_ADDR      = ADDR_BIT_WIDTH'(byte_to_word(KCTRL_BYTE_ADDR)),
  parameter int                        DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  mmio_key_device_if.slave   bus,
  input  logic [NKEYS-1:0]   key_in,
  output logic               irq
);

  logic [NKEYS-1:0] w_stable;
  logic [NKEYS-1:0] w_chg;
  logic [NKEYS-1:0] w_kdata;
  logic             w_event;
  logic             w_kdata_hit;
  logic             w_kctrl_hit;
  logic             w_ctrl_wr;
  logic             w_rdy_clr;
  logic             w_ovr_clr;
  logic             w_unused_data;
  logic [DBITS-1:0] w_kctrl;
  logic             r_rdy;
  logic             r_ovr;
  logic             r_ie;

  for (genvar g = 0; g < NKEYS; g++) begin : g_key
    mmio_key_device_key_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debouncer (
      .clk      (clk),
      .reset    (reset),
      .i_key_n  (key_in[g]),
      .o_stable (w_stable[g]),
      .o_chg    (w_chg[g])
    );
  end

  assign w_kdata     = ~w_stable;
  assign w_event     = |w_chg;
  assign w_kdata_hit = (bus.addr == KDATA_ADDR);
  assign w_kctrl_hit = (bus.addr == KCTRL_ADDR);
  assign w_ctrl_wr   = bus.en_write & w_kctrl_hit;
  assign w_rdy_clr   = (bus.en_read & w_kdata_hit) | (w_ctrl_wr & ~bus.data_in[KCTRL_RDY]);
  assign w_ovr_clr   = w_ctrl_wr & ~bus.data_in[KCTRL_OVR];
  assign w_unused_data = ^bus.data_in;

  // A new event only counts as an overrun if the previous one is still unread this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdy <= 1'b0;
      r_ovr <= 1'b0;
      r_ie  <= 1'b0;
    end else begin
      r_rdy <= w_event | (r_rdy & ~w_rdy_clr);
      r_ovr <= (w_event & r_rdy & ~w_rdy_clr) | (r_ovr & ~w_ovr_clr);
      if (w_ctrl_wr) begin
        r_ie <= bus.data_in[KCTRL_IE];
      end
    end
  end

  always_comb begin
    w_kctrl      = DBITS'(pack_kctrl(r_rdy, r_ovr, r_ie));
    bus.data_out = '0;
    if (w_kdata_hit) begin
      bus.data_out = DBITS'(w_kdata);
    end else if (w_kctrl_hit) begin
      bus.data_out = w_kctrl;
    end
  end

  assign bus.sel = w_kdata_hit | w_kctrl_hit;
  assign irq     = r_rdy & r_ie;

endmodule

// File: tb/tb_mmio_key_device.sv
// Directed bench for mmio_key_device with DEBOUNCE_CYCLES=4 and keys idle at 4'hF.
module tb_mmio_key_device;

  localparam int          DB     = 4;
  localparam logic [29:0] KD     = 30'h3FFFE020;
  localparam logic [29:0] KC     = 30'h3FFFE021;
  localparam logic [29:0] KMISS  = 30'h3FFFE022;

  logic       clk = 1'b0;
  logic       reset;
  logic       irq;
  logic [3:0] key_in;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q[$];

  mmio_key_device_if #(.DBITS(32), .ADDR_BIT_WIDTH(30)) bus ();

  mmio_key_device #(
    .DBITS           (32),
    .ADDR_BIT_WIDTH  (30),
    .NKEYS           (4),
    .KDATA_ADDR      (KD),
    .KCTRL_ADDR      (KC),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .key_in (key_in),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic compare(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic peek(input string tag, input logic [29:0] a, input logic [31:0] exp);
    sb_q.push_back(exp);
    bus.addr     = a;
    bus.en_read  = 1'b0;
    bus.en_write = 1'b0;
    #1;
    compare(tag, bus.data_out);
  endtask

  task automatic peek_sel(input string tag, input logic [29:0] a, input logic exp);
    sb_q.push_back({31'b0, exp});
    bus.addr     = a;
    bus.en_read  = 1'b0;
    bus.en_write = 1'b0;
    #1;
    compare(tag, {31'b0, bus.sel});
  endtask

  task automatic check_irq(input string tag, input logic exp);
    sb_q.push_back({31'b0, exp});
    compare(tag, {31'b0, irq});
  endtask

  task automatic rd_clr(input logic [29:0] a);
    bus.addr    = a;
    bus.en_read = 1'b1;
    step(1);
    bus.en_read = 1'b0;
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d);
    bus.addr     = a;
    bus.data_in  = d;
    bus.en_write = 1'b1;
    step(1);
    bus.en_write = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    key_in       = 4'hF;
    bus.addr     = '0;
    bus.en_read  = 1'b0;
    bus.en_write = 1'b0;
    bus.data_in  = '0;
    step(2);

    // Reset state
    peek("rst_kdata", KD, 32'h0);
    peek("rst_kctrl", KC, 32'h0);
    check_irq("rst_irq", 1'b0);
    step(1);
    peek_sel("rst_sel_kd", KD, 1'b1);

    // Reset asserted in the middle of a key0 debounce
    reset = 1'b1;
    step(2);
    key_in = 4'hE;
    step(3);
    reset = 1'b0;
    #1;
    peek("midrst_kdata", KD, 32'h0);
    peek("midrst_kctrl", KC, 32'h0);
    check_irq("midrst_irq", 1'b0);
    key_in = 4'hF;
    step(1);
    reset = 1'b1;
    step(10);
    peek("rel_kdata", KD, 32'h0);
    peek("rel_kctrl", KC, 32'h0);

    // Clean press of key0: visible exactly 6 edges later
    step(1);
    key_in = 4'hE;
    step(5);
    peek("press_kdata_5", KD, 32'h0);
    step(1);
    peek("press_kdata_6", KD, 32'h1);
    peek("press_kctrl", KC, 32'h1);
    peek_sel("press_sel_kc", KC, 1'b1);
    step(1);
    peek_sel("press_sel_kd", KD, 1'b1);
    rd_clr(KD);
    peek("rdclr_kctrl", KC, 32'h0);
    key_in = 4'hF;
    step(8);
    peek("rel0_kdata", KD, 32'h0);
    peek("rel0_kctrl", KC, 32'h1);
    rd_clr(KD);
    peek("rel0_clr", KC, 32'h0);

    // Bounce shorter than the debounce window
    key_in = 4'hE;
    step(3);
    key_in = 4'hF;
    step(10);
    peek("bounce_kdata", KD, 32'h0);
    peek("bounce_kctrl", KC, 32'h0);

    // Overrun: press then release key1 without reading, then clear by store
    key_in = 4'hD;
    step(8);
    peek("k1_kdata", KD, 32'h2);
    peek("k1_kctrl", KC, 32'h1);
    key_in = 4'hF;
    step(8);
    peek("k1rel_kdata", KD, 32'h0);
    peek("ovr_kctrl", KC, 32'h5);
    wr(KC, 32'h0);
    peek("wrclr_kctrl", KC, 32'h0);

    // Read-clear coinciding with a new event: set wins, no overrun
    key_in = 4'hB;
    step(8);
    peek("k2_kdata", KD, 32'h4);
    peek("k2_kctrl", KC, 32'h1);
    key_in = 4'hF;
    step(5);
    bus.addr    = KD;
    bus.en_read = 1'b1;
    step(1);
    bus.en_read = 1'b0;
    peek("coinc_kctrl", KC, 32'h1);
    peek("coinc_kdata", KD, 32'h0);
    rd_clr(KD);
    peek("coinc_clr", KC, 32'h0);

    // Interrupt enable, key3, irq cleared by a KDATA read; unmapped address
    wr(KC, 32'h10);
    peek("ie_kctrl", KC, 32'h10);
    check_irq("ie_irq_idle", 1'b0);
    key_in = 4'h7;
    step(8);
    check_irq("k3_irq", 1'b1);
    peek("k3_kdata", KD, 32'h8);
    peek("k3_kctrl", KC, 32'h11);
    rd_clr(KD);
    check_irq("k3_irq_clr", 1'b0);
    peek("k3_kctrl_clr", KC, 32'h10);
    peek("miss_data", KMISS, 32'h0);
    peek_sel("miss_sel", KMISS, 1'b0);
    step(1);
    wr(KD, 32'h0);
    peek("kdata_wr_ignored", KC, 32'h10);
    wr(KMISS, 32'h0);
    peek("miss_wr_ignored", KC, 32'h10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
